// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone RAM arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    localparam int PW = $clog2(NUM_REQ);

    int w_idx;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        w_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(last) + k) % NUM_REQ;
            if (!valid && req[PW'(w_idx)]) begin
                win[PW'(w_idx)] = 1'b1;
                valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin arbiter sharing one big_ram Wishbone port between NUM_REQ
// requesters; ownership lasts for the owner's whole cyc.
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           m_wb_cyc_i,
    input  logic [NUM_REQ-1:0]           m_wb_stb_i,
    input  logic [NUM_REQ-1:0]           m_wb_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    m_wb_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]    m_wb_data_i,
    input  logic [NUM_REQ*DATA_W/8-1:0]  m_wb_sel_i,
    output logic [NUM_REQ-1:0]           m_wb_ack_o,
    output logic [NUM_REQ-1:0]           m_wb_stall_o,
    output logic [DATA_W-1:0]            m_wb_data_o,
    output logic                         s_wb_cyc_o,
    output logic                         s_wb_stb_o,
    output logic                         s_wb_we_o,
    output logic [ADDR_W-1:0]            s_wb_addr_o,
    output logic [DATA_W-1:0]            s_wb_data_o,
    output logic [DATA_W/8-1:0]          s_wb_sel_o,
    input  logic                         s_wb_ack_i,
    input  logic                         s_wb_stall_i,
    input  logic [DATA_W-1:0]            s_wb_data_i,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         busy_o
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     w_last_nxt;
    logic [NUM_REQ-1:0]   w_win;
    logic                 w_win_vld;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_own_cyc;
    logic                 w_arb;
    logic                 w_own_act;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (m_wb_cyc_i),
        .last  (r_last),
        .win   (w_win),
        .valid (w_win_vld)
    );

    assign w_win_idx = onehot2idx(MAX_REQ'(w_win));
    assign w_own_cyc = |(r_grant & m_wb_cyc_i);
    // Re-arbitrate whenever nobody owns the port or the owner has let go of cyc.
    assign w_arb     = (r_state == IDLE) || !w_own_cyc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        if (w_arb) begin
            if (w_win_vld) begin
                w_state_nxt = OWN;
                w_grant_nxt = w_win;
                w_last_nxt  = w_win_idx;
            end else begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        end
    end

    always_comb begin
        w_own_act   = (r_state == OWN) && w_own_cyc;
        s_wb_cyc_o  = w_own_act;
        s_wb_stb_o  = w_own_act && |(r_grant & m_wb_stb_i);
        s_wb_we_o   = |(r_grant & m_wb_we_i);
        s_wb_addr_o = '0;
        s_wb_data_o = '0;
        s_wb_sel_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                s_wb_addr_o = s_wb_addr_o | m_wb_addr_i[i*ADDR_W +: ADDR_W];
                s_wb_data_o = s_wb_data_o | m_wb_data_i[i*DATA_W +: DATA_W];
                s_wb_sel_o  = s_wb_sel_o  | m_wb_sel_i[i*SEL_W +: SEL_W];
            end
        end
        // A late ack after an abort finds cyc low here and is dropped.
        m_wb_ack_o   = r_grant & {NUM_REQ{s_wb_ack_i & w_own_act}};
        m_wb_stall_o = ~r_grant | (r_grant & {NUM_REQ{s_wb_stall_i}});
        m_wb_data_o  = s_wb_data_i;
        grant_o      = r_grant;
        busy_o       = (r_state == OWN);
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter with a behavioural RAM and a rule-level
// model of round-robin ownership.
module tb_wb_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    logic [N-1:0]    m_wb_cyc_i, m_wb_stb_i, m_wb_we_i;
    logic [N*AW-1:0] m_wb_addr_i;
    logic [N*DW-1:0] m_wb_data_i;
    logic [N*SW-1:0] m_wb_sel_i;
    logic [N-1:0]    m_wb_ack_o, m_wb_stall_o;
    logic [DW-1:0]   m_wb_data_o;
    logic            s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
    logic [AW-1:0]   s_wb_addr_o;
    logic [DW-1:0]   s_wb_data_o;
    logic [SW-1:0]   s_wb_sel_o;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    logic            ram_ack   = 1'b0;
    logic            ram_stall = 1'b0;
    logic [DW-1:0]   ram_rdata = '0;
    logic [DW-1:0]   ram_mem [0:(1<<AW)-1] = '{default: '0};
    bit              stall_en  = 1'b0;

    wb_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .m_wb_cyc_i   (m_wb_cyc_i),
        .m_wb_stb_i   (m_wb_stb_i),
        .m_wb_we_i    (m_wb_we_i),
        .m_wb_addr_i  (m_wb_addr_i),
        .m_wb_data_i  (m_wb_data_i),
        .m_wb_sel_i   (m_wb_sel_i),
        .m_wb_ack_o   (m_wb_ack_o),
        .m_wb_stall_o (m_wb_stall_o),
        .m_wb_data_o  (m_wb_data_o),
        .s_wb_cyc_o   (s_wb_cyc_o),
        .s_wb_stb_o   (s_wb_stb_o),
        .s_wb_we_o    (s_wb_we_o),
        .s_wb_addr_o  (s_wb_addr_o),
        .s_wb_data_o  (s_wb_data_o),
        .s_wb_sel_o   (s_wb_sel_o),
        .s_wb_ack_i   (ram_ack),
        .s_wb_stall_i (ram_stall),
        .s_wb_data_i  (ram_rdata),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    // Pipelined RAM: accepts when not stalled, acks exactly one cycle later.
    always @(posedge clk_i) begin
        ram_stall <= stall_en && ($urandom_range(0, 3) == 0);
        ram_ack   <= 1'b0;
        if (s_wb_cyc_o && s_wb_stb_o && !ram_stall) begin
            ram_ack <= 1'b1;
            if (s_wb_we_o) begin
                for (int b = 0; b < SW; b++)
                    if (s_wb_sel_o[b]) ram_mem[s_wb_addr_o][8*b +: 8] <= s_wb_data_o[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[s_wb_addr_o];
            end
        end
    end

    logic          d_cyc  [N] = '{default: 1'b0};
    logic          d_stb  [N] = '{default: 1'b0};
    logic          d_we   [N] = '{default: 1'b0};
    logic [AW-1:0] d_addr [N] = '{default: '0};
    logic [DW-1:0] d_data [N] = '{default: '0};
    logic [SW-1:0] d_sel  [N] = '{default: '0};
    logic          mon_ack   [N];
    logic          mon_stall [N];

    for (genvar g = 0; g < N; g++) begin : g_map
        assign m_wb_cyc_i[g]            = d_cyc[g];
        assign m_wb_stb_i[g]            = d_stb[g];
        assign m_wb_we_i[g]             = d_we[g];
        assign m_wb_addr_i[g*AW +: AW]  = d_addr[g];
        assign m_wb_data_i[g*DW +: DW]  = d_data[g];
        assign m_wb_sel_i[g*SW +: SW]   = d_sel[g];
        assign mon_ack[g]               = m_wb_ack_o[g];
        assign mon_stall[g]             = m_wb_stall_o[g];
    end

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
        bit            eob;
        bit            abort;
        int            dly;
    } op_t;

    typedef struct {
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;

    op_t           cmd_q [N][$];
    exp_t          exp_q [N][$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};

    bit act [N], armed [N], all_iss [N], abort_b [N];
    int outst [N], gap [N], dly_left [N];

    int  n_chk = 0, n_fail = 0, tmo_cnt = 0;
    int  ref_owner = -1, ref_last = N - 1;
    bit  end_req = 1'b0, end_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_chk++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act_v, exp_v);
        end
    endtask

    // Monitor: ownership rules, routing, and read data against the scoreboard.
    always @(negedge clk_i) begin
        logic [N-1:0] eg, ea, es;
        logic         scyc;
        exp_t         e;
        if (!rst_ni) begin
            chk("rst_grant", 64'(grant_o), 64'(0));
            chk("rst_busy", 64'(busy_o), 64'(0));
            chk("rst_s_cyc_stb", 64'({s_wb_cyc_o, s_wb_stb_o}), 64'(0));
            chk("rst_ack", 64'(m_wb_ack_o), 64'(0));
            chk("rst_stall", 64'(m_wb_stall_o), 64'({N{1'b1}}));
            ref_owner = -1;
            ref_last  = N - 1;
        end else begin
            eg   = (ref_owner < 0) ? '0 : (N'(1) << ref_owner);
            scyc = (ref_owner >= 0) && d_cyc[ref_owner];
            ea   = (scyc && ram_ack) ? eg : '0;
            es   = ~eg | (ram_stall ? eg : '0);
            chk("grant", 64'(grant_o), 64'(eg));
            chk("busy", 64'(busy_o), 64'(ref_owner >= 0));
            chk("s_cyc", 64'(s_wb_cyc_o), 64'(scyc));
            chk("ack_route", 64'(m_wb_ack_o), 64'(ea));
            chk("stall", 64'(m_wb_stall_o), 64'(es));
            if (scyc) begin
                chk("s_stb", 64'(s_wb_stb_o), 64'(d_stb[ref_owner]));
                if (d_stb[ref_owner]) begin
                    chk("s_addr", 64'(s_wb_addr_o), 64'(d_addr[ref_owner]));
                    chk("s_we", 64'(s_wb_we_o), 64'(d_we[ref_owner]));
                    if (d_we[ref_owner]) begin
                        chk("s_data", 64'(s_wb_data_o), 64'(d_data[ref_owner]));
                        chk("s_sel", 64'(s_wb_sel_o), 64'(d_sel[ref_owner]));
                    end
                end
            end
            for (int r = 0; r < N; r++) begin
                if (mon_ack[r]) begin
                    if (exp_q[r].size() == 0) begin
                        chk($sformatf("ack_without_access_p%0d", r), 64'(mon_ack[r]), 64'(0));
                    end else begin
                        e = exp_q[r].pop_front();
                        if (e.rd) chk($sformatf("rdata_p%0d", r), 64'(m_wb_data_o), 64'(e.data));
                    end
                end
            end
            if (ref_owner < 0 || !d_cyc[ref_owner]) begin
                ref_owner = -1;
                for (int k = 1; k <= N; k++) begin
                    if (ref_owner < 0 && d_cyc[(ref_last + k) % N]) begin
                        ref_owner = (ref_last + k) % N;
                        ref_last  = ref_owner;
                    end
                end
            end
        end
        if (end_req && !end_done) begin
            for (int r = 0; r < N; r++)
                chk($sformatf("pending_acks_p%0d", r), 64'(exp_q[r].size()), 64'(0));
            chk("timeouts", 64'(tmo_cnt), 64'(0));
            end_done = 1'b1;
        end
    end

    task automatic push_op(input int r, input bit we, input int addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] sel, input bit eob, input bit abort, input int dly);
        op_t o;
        o.we = we; o.addr = AW'(addr); o.data = data; o.sel = sel;
        o.eob = eob; o.abort = abort; o.dly = dly;
        cmd_q[r].push_back(o);
    endtask

    task automatic accept(input int r);
        op_t  o;
        exp_t e;
        o = cmd_q[r].pop_front();
        e.rd = !o.we;
        e.data = ref_mem[o.addr];
        if (o.we)
            for (int b = 0; b < SW; b++)
                if (o.sel[b]) ref_mem[o.addr][8*b +: 8] = o.data[8*b +: 8];
        if (!o.abort) begin
            exp_q[r].push_back(e);
            outst[r]++;
        end
        if (o.eob) begin
            all_iss[r] = 1'b1;
            abort_b[r] = o.abort;
        end
    endtask

    task automatic drive(input int r);
        if (!act[r]) begin
            d_cyc[r] = 1'b0;
            d_stb[r] = 1'b0;
            if (gap[r] > 0) gap[r]--;
            else if (cmd_q[r].size() > 0) begin
                if (!armed[r]) begin
                    armed[r] = 1'b1;
                    dly_left[r] = cmd_q[r][0].dly;
                end
                if (dly_left[r] > 0) dly_left[r]--;
                else begin
                    act[r] = 1'b1; armed[r] = 1'b0; all_iss[r] = 1'b0;
                    abort_b[r] = 1'b0; outst[r] = 0;
                end
            end
        end
        if (act[r]) begin
            if (all_iss[r] && (abort_b[r] || outst[r] == 0)) begin
                act[r] = 1'b0; gap[r] = 1; outst[r] = 0;
                d_cyc[r] = 1'b0; d_stb[r] = 1'b0;
            end else begin
                d_cyc[r] = 1'b1;
                d_stb[r] = 1'b0;
                if (!all_iss[r] && cmd_q[r].size() > 0) begin
                    d_stb[r]  = 1'b1;
                    d_we[r]   = cmd_q[r][0].we;
                    d_addr[r] = cmd_q[r][0].addr;
                    d_data[r] = cmd_q[r][0].data;
                    d_sel[r]  = cmd_q[r][0].sel;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        for (int r = 0; r < N; r++) begin
            if (d_stb[r] && !mon_stall[r]) accept(r);
            if (mon_ack[r] && outst[r] > 0) outst[r]--;
        end
        @(posedge clk_i);
        #1;
        for (int r = 0; r < N; r++) drive(r);
    endtask

    function automatic bit all_idle();
        for (int r = 0; r < N; r++)
            if (act[r] || cmd_q[r].size() > 0 || exp_q[r].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_drivers();
        for (int r = 0; r < N; r++) begin
            cmd_q[r].delete(); exp_q[r].delete();
            act[r] = 1'b0; armed[r] = 1'b0; all_iss[r] = 1'b0; abort_b[r] = 1'b0;
            outst[r] = 0; gap[r] = 0; dly_left[r] = 0;
            d_cyc[r] = 1'b0; d_stb[r] = 1'b0;
        end
    endtask

    task automatic run_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc && !all_idle(); i++) step();
        if (!all_idle()) begin
            tmo_cnt++;
            clear_drivers();
        end
        repeat (2) step();
    endtask

    initial begin
        int r, n;
        clear_drivers();
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (2) step();

        // Single requester write then read-back.
        push_op(0, 1, 4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        push_op(0, 0, 4, '0, 4'hF, 1, 0, 0);
        run_idle(100);

        // Four simultaneous requesters, each writes and reads its own word.
        for (int i = 0; i < N; i++) begin
            push_op(i, 1, 100 + i, $urandom, 4'hF, 0, 0, 0);
            push_op(i, 0, 100 + i, '0, 4'hF, 1, 0, 0);
        end
        run_idle(200);

        // Requester 2 holds three pipelined reads while requester 1 waits.
        push_op(2, 0, 100, '0, 4'hF, 0, 0, 0);
        push_op(2, 0, 101, '0, 4'hF, 0, 0, 0);
        push_op(2, 0, 102, '0, 4'hF, 1, 0, 0);
        push_op(1, 0, 103, '0, 4'hF, 1, 0, 2);
        run_idle(200);

        // Partial write merges into the previous word.
        push_op(0, 1, 10, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        push_op(0, 1, 10, 32'h00001122, 4'h3, 0, 0, 0);
        push_op(0, 0, 10, '0, 4'hF, 1, 0, 0);
        run_idle(100);

        // Requester 3 aborts its read; requester 0 follows with its own read.
        push_op(3, 0, 103, '0, 4'hF, 1, 1, 0);
        push_op(0, 0, 100, '0, 4'hF, 1, 0, 1);
        run_idle(100);

        // Randomized traffic with RAM back-pressure and occasional aborts.
        stall_en = 1'b1;
        for (int b = 0; b < 40; b++) begin
            r = $urandom_range(0, N - 1);
            if ($urandom_range(0, 5) == 0) begin
                push_op(r, 0, $urandom_range(0, 31), '0, 4'hF, 1, 1, $urandom_range(0, 3));
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++)
                    push_op(r, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom,
                            4'($urandom_range(1, 15)), k == n - 1, 0,
                            (k == 0) ? $urandom_range(0, 3) : 0);
            end
        end
        run_idle(3000);
        stall_en = 1'b0;
        repeat (2) step();

        // Reset while requester 1 has a read in flight.
        push_op(1, 0, 4, '0, 4'hF, 1, 0, 0);
        for (int i = 0; i < 50 && outst[1] == 0; i++) step();
        #1 rst_ni = 1'b0;
        clear_drivers();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        push_op(2, 0, 102, '0, 4'hF, 1, 0, 0);
        push_op(0, 0, 100, '0, 4'hF, 1, 0, 0);
        run_idle(100);

        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_done; i++) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
